// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int STAT_W = 16;

    // Ceiling log2, used for index and counter widths
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester and FIFO-write-side signals of the write arbiter.
// master: the arbiter; slave: requesters plus FIFO feedback.
interface fifo_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DATA  = 8,
    parameter int ADDR  = 4
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*DATA-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  write_req;
    logic [DATA-1:0]       write_data;
    logic                  fifo_pop;
    logic [ADDR:0]         credits;
    logic                  cred_err;

    modport master (
        input  req_valid, req_data, fifo_pop,
        output req_ready, write_req, write_data, credits, cred_err
    );

    modport slave (
        output req_valid, req_data, fifo_pop,
        input  req_ready, write_req, write_data, credits, cred_err
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or after start, wrapping.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    start,
    output logic [N_REQ-1:0] grant,
    output logic             found,
    output logic [IW-1:0]    idx
);

    // Scan farthest-to-nearest so the nearest valid index is written last
    always_comb begin
        int pos;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                found      = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between N_REQ producers with round-robin burst
// arbitration and a local credit counter that mirrors FIFO free space.
// Optional build macro: ARB_STATS_EN adds the per-requester grant_cnt port.
//
// state | meaning
// IDLE  | no owner; pick next valid requester from rr_ptr this cycle
// BURST | owner keeps the port while valid, under MAX_BURST and with credit
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA      = 8,
    parameter int ADDR      = 4,
    parameter int MAX_BURST = 4
) (
    input logic clk,
    input logic rst,
    fifo_write_arbiter_if.master bus
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] grant_cnt
`endif
);

    localparam int IW = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);
    localparam int BW = (clog2(MAX_BURST + 1) < 1) ? 1 : clog2(MAX_BURST + 1);
    localparam logic [ADDR:0] FULL = {1'b1, {ADDR{1'b0}}};

    state_t            state, state_n;
    logic [IW-1:0]     owner, owner_n, rr_ptr, rr_ptr_n, pick_idx, acc_idx;
    logic [BW-1:0]     beat_cnt, beat_n;
    logic [ADDR:0]     credits, credits_n;
    logic [N_REQ-1:0]  pick_grant, ready;
    logic              pick_found, accept;
    logic              write_req_q, cred_err_q;
    logic [DATA-1:0]   write_data_q;

    rr_priority_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
        .req   (bus.req_valid),
        .start (rr_ptr),
        .grant (pick_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant selection and FSM next state; an owner dropping valid falls
    // straight through to a fresh pick so no bubble is inserted
    always_comb begin
        state_n  = IDLE;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        beat_n   = beat_cnt;
        ready    = '0;
        accept   = 1'b0;
        acc_idx  = owner;
        if (state == BURST && bus.req_valid[owner]) begin
            if (credits != '0) begin
                ready[owner] = 1'b1;
                accept       = 1'b1;
                beat_n       = beat_cnt + 1'b1;
            end
        end else if (pick_found && credits != '0) begin
            ready    = pick_grant;
            accept   = 1'b1;
            acc_idx  = pick_idx;
            owner_n  = pick_idx;
            beat_n   = BW'(1);
            rr_ptr_n = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
        end
        if (accept && beat_n != BW'(MAX_BURST) && credits_n != '0) state_n = BURST;
    end

    // Credit bookkeeping; a pop with all credits home is ignored (and flagged)
    always_comb begin
        credits_n = credits;
        case ({accept, bus.fifo_pop})
            2'b10:   credits_n = credits - 1'b1;
            2'b01:   if (credits != FULL) credits_n = credits + 1'b1;
            default: credits_n = credits;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_n;
        end
    end

    // Credit counter and registered FIFO write outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            credits      <= FULL;
            write_req_q  <= 1'b0;
            write_data_q <= '0;
            cred_err_q   <= 1'b0;
        end else begin
            credits     <= credits_n;
            write_req_q <= accept;
            if (accept) write_data_q <= bus.req_data[int'(acc_idx)*DATA +: DATA];
            cred_err_q  <= bus.fifo_pop && (credits == FULL);
        end
    end

    assign bus.req_ready  = rst ? '0 : ready;
    assign bus.write_req  = write_req_q;
    assign bus.write_data = write_data_q;
    assign bus.credits    = credits;
    assign bus.cred_err   = cred_err_q;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [N_REQ];

    // Saturating per-requester accepted-beat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
        end else if (accept && stat_q[acc_idx] != '1) begin
            stat_q[acc_idx] <= stat_q[acc_idx] + 1'b1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign grant_cnt[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: one instance with MAX_BURST=4 and
// one with MAX_BURST=1 share the same stimulus; a transaction-level model
// predicts grants, credits and written data for each.
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk;
    logic        drv_rst;
    logic [3:0]  drv_valid;
    logic [31:0] drv_data;
    logic        drv_pop;

    fifo_write_arbiter_if #(.N_REQ(N), .DATA(DW), .ADDR(AW)) if_b ();
    fifo_write_arbiter_if #(.N_REQ(N), .DATA(DW), .ADDR(AW)) if_s ();

`ifdef ARB_STATS_EN
    logic [63:0] gc_b, gc_s;
`endif

    fifo_write_arbiter #(.N_REQ(N), .DATA(DW), .ADDR(AW), .MAX_BURST(4)) dut_b (
        .clk (clk),
        .rst (drv_rst),
        .bus (if_b)
`ifdef ARB_STATS_EN
        , .grant_cnt (gc_b)
`endif
    );

    fifo_write_arbiter #(.N_REQ(N), .DATA(DW), .ADDR(AW), .MAX_BURST(1)) dut_s (
        .clk (clk),
        .rst (drv_rst),
        .bus (if_s)
`ifdef ARB_STATS_EN
        , .grant_cnt (gc_s)
`endif
    );

    assign if_b.req_valid = drv_valid;
    assign if_b.req_data  = drv_data;
    assign if_b.fifo_pop  = drv_pop;
    assign if_s.req_valid = drv_valid;
    assign if_s.req_data  = drv_data;
    assign if_s.fifo_pop  = drv_pop;

    logic [3:0] rdy [2];
    logic       wr  [2];
    logic [7:0] wd  [2];
    logic [4:0] cr  [2];
    logic       ce  [2];
    assign rdy[0] = if_b.req_ready;  assign rdy[1] = if_s.req_ready;
    assign wr[0]  = if_b.write_req;  assign wr[1]  = if_s.write_req;
    assign wd[0]  = if_b.write_data; assign wd[1]  = if_s.write_data;
    assign cr[0]  = if_b.credits;    assign cr[1]  = if_s.credits;
    assign ce[0]  = if_b.cred_err;   assign ce[1]  = if_s.cred_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 0;
    bit rec_on   = 0;

    // Reference model state (owner = -1 means nobody holds the port)
    int         m_owner [2];
    int         m_beats [2];
    int         m_ptr   [2];
    int         m_cred  [2];
    int         m_grant [2];
    bit         m_newb  [2];
    bit         m_wr    [2];
    bit         m_err   [2];
    logic [3:0] exp_ready [2];
    int         m_cnt [2][4];
    int         wr_cnt [2];
    int         err_cnt [2];
    int         q_b[$], q_s[$];
    int         obs_b[$], obs_s[$];

    function automatic void chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, d, act, exp, $time);
        end
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q_b.size() : q_s.size();
    endfunction

    function automatic void q_push(input int d, input int v);
        if (d == 0) q_b.push_back(v); else q_s.push_back(v);
    endfunction

    function automatic int q_pop(input int d);
        if (d == 0) return q_b.pop_front();
        return q_s.pop_front();
    endfunction

    function automatic void model_reset(input int d);
        m_owner[d] = -1; m_beats[d] = 0; m_ptr[d] = 0; m_cred[d] = DEPTH;
        m_wr[d] = 0; m_err[d] = 0;
        for (int i = 0; i < N; i++) m_cnt[d][i] = 0;
        if (d == 0) q_b.delete(); else q_s.delete();
    endfunction

    // Which requester is served this cycle, from the current inputs
    function automatic void model_eval(input int d);
        int i;
        m_grant[d]   = -1;
        m_newb[d]    = 0;
        exp_ready[d] = '0;
        if (drv_rst || m_cred[d] == 0) return;
        if (m_owner[d] >= 0 && drv_valid[m_owner[d]]) begin
            m_grant[d] = m_owner[d];
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr[d] + k) % N;
                if (drv_valid[i]) begin
                    m_grant[d] = i;
                    m_newb[d]  = 1;
                    break;
                end
            end
        end
        if (m_grant[d] >= 0) exp_ready[d][m_grant[d]] = 1'b1;
    endfunction

    // Apply the clock edge to the model
    function automatic void model_commit(input int d);
        int g, mb;
        g  = m_grant[d];
        mb = (d == 0) ? 4 : 1;
        if (drv_rst) begin
            model_reset(d);
            return;
        end
        m_err[d] = drv_pop && (m_cred[d] == DEPTH);
        m_wr[d]  = (g >= 0);
        if (g >= 0) begin
            q_push(d, int'(drv_data[g*8 +: 8]));
            if (m_cnt[d][g] < 65535) m_cnt[d][g]++;
            if (m_newb[d]) begin
                m_owner[d] = g;
                m_beats[d] = 1;
                m_ptr[d]   = (g + 1) % N;
            end else begin
                m_beats[d]++;
            end
        end
        if (g >= 0 && !drv_pop) m_cred[d]--;
        else if (g < 0 && drv_pop && m_cred[d] < DEPTH) m_cred[d]++;
        if (!(g >= 0 && m_beats[d] < mb && m_cred[d] > 0)) m_owner[d] = -1;
    endfunction

    task automatic step(input logic [3:0] v, input logic [31:0] dat, input logic p, input logic r);
        drv_valid = v;
        drv_data  = dat;
        drv_pop   = p;
        drv_rst   = r;
        model_eval(0);
        model_eval(1);
        @(posedge clk);
        model_commit(0);
        model_commit(1);
        #1;
    endtask

    // Monitor: compares every cycle, pops the scoreboard on each FIFO write
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk("req_ready", d, 32'(rdy[d]), 32'(exp_ready[d]));
                chk("credits",   d, 32'(cr[d]),  32'(m_cred[d]));
                chk("write_req", d, 32'(wr[d]),  32'(m_wr[d]));
                chk("cred_err",  d, 32'(ce[d]),  32'(m_err[d]));
                if (wr[d] === 1'b1) begin
                    wr_cnt[d]++;
                    chk("sb_nonempty", d, 32'(q_size(d) > 0), 32'd1);
                    if (q_size(d) > 0) chk("write_data", d, 32'(wd[d]), 32'(q_pop(d)));
                    if (rec_on) begin
                        if (d == 0) obs_b.push_back(int'(wd[d]));
                        else        obs_s.push_back(int'(wd[d]));
                    end
                end
                if (ce[d] === 1'b1) err_cnt[d]++;
`ifdef ARB_STATS_EN
                for (int i = 0; i < N; i++)
                    chk("grant_cnt", d, 32'(d == 0 ? gc_b[i*16 +: 16] : gc_s[i*16 +: 16]), 32'(m_cnt[d][i]));
`endif
            end
        end
    end

    initial begin
        int base [2];
        int exp_b [8];
        int exp_s [5];
        logic [3:0] hv;
        exp_b = '{'hA0, 'hA0, 'hA0, 'hA0, 'hA1, 'hA1, 'hA1, 'hA1};
        exp_s = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0};
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            wr_cnt[d] = 0;
            err_cnt[d] = 0;
        end
        drv_rst = 1'b1; drv_valid = '0; drv_data = '0; drv_pop = 1'b0;

        // Reset for two cycles
        step(4'h0, 32'h0, 1'b0, 1'b1);
        armed = 1;
        step(4'hF, 32'h0, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk("rst_credits", d, 32'(cr[d]), 32'd16);
            chk("rst_ready",   d, 32'(rdy[d]), 32'd0);
            chk("rst_wr",      d, 32'(wr[d]), 32'd0);
        end
        step(4'h0, 32'h0, 1'b0, 1'b0);

        // All four valid, FIFO drained behind the writes
        rec_on = 1;
        for (int k = 0; k < 12; k++) step(4'hF, 32'hA3A2A1A0, k > 0, 1'b0);
        rec_on = 0;
        chk("burst_seq_len", 0, 32'(obs_b.size() >= 8), 32'd1);
        chk("rr_seq_len",    1, 32'(obs_s.size() >= 5), 32'd1);
        for (int i = 0; i < 8; i++)
            if (i < obs_b.size()) chk("burst_seq", 0, 32'(obs_b[i]), 32'(exp_b[i]));
        for (int i = 0; i < 5; i++)
            if (i < obs_s.size()) chk("rr_seq", 1, 32'(obs_s[i]), 32'(exp_s[i]));
        step(4'h0, 32'h0, 1'b1, 1'b0);

        // Requester 2 alone, no pops: fills to zero credit, then 3 pops
        base[0] = wr_cnt[0]; base[1] = wr_cnt[1];
        for (int k = 0; k < 21; k++) step(4'b0100, $urandom, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("fill_writes",  d, 32'(wr_cnt[d] - base[d]), 32'd16);
            chk("fill_credits", d, 32'(cr[d]), 32'd0);
        end
        for (int k = 0; k < 3; k++) step(4'b0100, $urandom, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0100, $urandom, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++)
            chk("refill_writes", d, 32'(wr_cnt[d] - base[d]), 32'd19);

        // Drain to full, then one pop too many
        base[0] = err_cnt[0]; base[1] = err_cnt[1];
        for (int k = 0; k < 17; k++) step(4'h0, 32'h0, 1'b1, 1'b0);
        step(4'h0, 32'h0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("cred_err_pulses", d, 32'(err_cnt[d] - base[d]), 32'd1);
            chk("full_credits",    d, 32'(cr[d]), 32'd16);
        end

        // Accept and pop together at credits=5
        for (int k = 0; k < 11; k++) step(4'b0001, $urandom, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) chk("credits5", d, 32'(cr[d]), 32'd5);
        step(4'b0001, $urandom, 1'b1, 1'b0);
        for (int d = 0; d < 2; d++) chk("accept_pop_hold", d, 32'(cr[d]), 32'd5);
        for (int k = 0; k < 11; k++) step(4'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic: per-cycle valids, then slowly changing valids
        for (int k = 0; k < 400; k++)
            step(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        hv = 4'hF;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) hv = 4'($urandom_range(0, 15));
            step(hv, $urandom, 1'($urandom_range(0, 2) == 0), 1'b0);
        end

        // Reset mid-burst after two beats
        step(4'h0, 32'h0, 1'b0, 1'b1);
        step(4'hF, $urandom, 1'b0, 1'b0);
        step(4'hF, $urandom, 1'b0, 1'b0);
        step(4'hF, $urandom, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk("midrst_credits", d, 32'(cr[d]), 32'd16);
            chk("midrst_wr",      d, 32'(wr[d]), 32'd0);
        end
`ifdef ARB_STATS_EN
        chk("midrst_stats", 0, gc_b[31:0] | gc_b[63:32], 32'd0);
        chk("midrst_stats", 1, gc_s[31:0] | gc_s[63:32], 32'd0);
`endif
        for (int k = 0; k < 60; k++)
            step(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        step(4'h0, 32'h0, 1'b0, 1'b0);
        step(4'h0, 32'h0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) chk("sb_drained", d, 32'(q_size(d)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
